// File: rtl/port_seq_pkg.sv
// Shared constants for the AHB port sequencer: bus codes, register map,
// register bit positions and the sequencer state type.
package port_seq_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_FLUSH_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STAT_LEVEL_MSB = 8;
    localparam int STAT_EMPTY_BIT = 16;
    localparam int STAT_FULL_BIT  = 17;
    localparam int STAT_OVF_BIT   = 18;

    typedef enum logic {IDLE, HOLD} state_t;

endpackage

// File: rtl/seq_fifo.sv
// Synchronous first-word-fall-through FIFO holding the queued port values.
// Pointers carry one extra bit so full and empty are distinguishable.
module seq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is still accepted when a pop frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign level = wptr - rptr;
    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge HCLK) begin
        if (!HRESETn || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; entries are only visible between rptr and wptr.
    always_ff @(posedge HCLK) begin
        if (do_push && !flush) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ahb_port_sequencer.sv
// AHB-Lite slave that plays queued words onto oPort, one per PERIOD+1 cycles.
// Optional build macro PORT_SEQ_IRQ_EN adds the irq output and CTRL irq_en bit.
module ahb_port_sequencer
    import port_seq_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] PERIOD_RST = 32'd0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
`ifdef PORT_SEQ_IRQ_EN
    output logic        irq,
`endif
    output logic [31:0] oPort,
    output logic        busy
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic          write_en;
    logic          read_en;
    logic [1:0]    addr;
    logic          access;
    logic          wr_data, wr_period, wr_ctrl, wr_status;
    logic          push, pop, flush;
    logic [31:0]   period;
    logic [31:0]   cnt;
    logic          enable;
    logic          overflow;
    state_t        state;
    logic [31:0]   fifo_head;
    logic [LW-1:0] fifo_level;
    logic          fifo_empty;
    logic          fifo_full;
    logic [31:0]   rdata;
    logic          unused_ok;
`ifdef PORT_SEQ_IRQ_EN
    logic          irq_en;
`endif

    assign HREADYOUT = 1'b1;
    assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0]};

    assign access = HREADY & HSEL & (HTRANS != HTRANS_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            write_en <= 1'b0;
            read_en  <= 1'b0;
            addr     <= ADDR_DATA;
        end else begin
            write_en <= access & HWRITE;
            read_en  <= access & ~HWRITE;
            if (access) addr <= HADDR[3:2];
        end
    end

    assign wr_data   = write_en & (addr == ADDR_DATA);
    assign wr_period = write_en & (addr == ADDR_PERIOD);
    assign wr_ctrl   = write_en & (addr == ADDR_CTRL);
    assign wr_status = write_en & (addr == ADDR_STATUS);

    assign push  = wr_data;
    assign flush = wr_ctrl & HWDATA[CTRL_FLUSH_BIT];
    assign pop   = ~flush & enable & ~fifo_empty & ((state == IDLE) | (cnt == '0));

    seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wdata   (HWDATA),
        .rdata   (fifo_head),
        .level   (fifo_level),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            period   <= PERIOD_RST;
            enable   <= 1'b0;
            overflow <= 1'b0;
`ifdef PORT_SEQ_IRQ_EN
            irq_en   <= 1'b0;
`endif
        end else begin
            if (wr_period) period <= HWDATA;
            if (wr_ctrl) begin
                enable <= HWDATA[CTRL_EN_BIT];
`ifdef PORT_SEQ_IRQ_EN
                irq_en <= HWDATA[CTRL_IRQ_EN_BIT];
`endif
            end
            if (push && fifo_full && !pop) overflow <= 1'b1;
            else if (wr_status && HWDATA[STAT_OVF_BIT]) overflow <= 1'b0;
        end
    end

    // cnt counts down the remaining hold cycles; the head is popped when it reaches 0.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= IDLE;
            cnt   <= '0;
            oPort <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        oPort <= fifo_head;
                        cnt   <= period;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 32'd1;
                    end else if (pop) begin
                        oPort <= fifo_head;
                        cnt   <= period;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == HOLD);

`ifdef PORT_SEQ_IRQ_EN
    always_ff @(posedge HCLK) begin
        if (!HRESETn) irq <= 1'b0;
        else          irq <= irq_en & (fifo_empty | overflow);
    end
`endif

    // NOTE: defaulting rdata first keeps this block free of inferred latches.
    always_comb begin
        rdata = '0;
        if (read_en) begin
            unique case (addr)
                ADDR_DATA:   rdata = oPort;
                ADDR_PERIOD: rdata = period;
                ADDR_CTRL: begin
                    rdata[CTRL_EN_BIT] = enable;
`ifdef PORT_SEQ_IRQ_EN
                    rdata[CTRL_IRQ_EN_BIT] = irq_en;
`endif
                end
                ADDR_STATUS: begin
                    rdata[STAT_LEVEL_MSB:0] = 9'(fifo_level);
                    rdata[STAT_EMPTY_BIT]   = fifo_empty;
                    rdata[STAT_FULL_BIT]    = fifo_full;
                    rdata[STAT_OVF_BIT]     = overflow;
                end
            endcase
        end
    end

    assign HRDATA = rdata;

endmodule

// File: tb/tb_ahb_port_sequencer.sv
// Scoreboard bench for ahb_port_sequencer: read expectations and oPort
// transitions (value plus cycle gap) are queued by stimulus and popped by monitors.
module tb_ahb_port_sequencer;

    localparam int DEPTH = 8;
    localparam logic [1:0] A_DATA = 2'd0, A_PERIOD = 2'd1, A_CTRL = 2'd2, A_STATUS = 2'd3;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] HADDR = '0;
    logic [31:0] HWDATA = '0;
    logic [2:0]  HSIZE = 3'b010;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic        HREADY = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [31:0] oPort;
    logic        busy;
`ifdef PORT_SEQ_IRQ_EN
    logic        irq;
`endif

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

    typedef struct {
        string       name;
        logic [31:0] val;
        int          gap;
    } port_exp_t;

    rd_exp_t   rd_q[$];
    port_exp_t port_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    ahb_port_sequencer #(
        .DEPTH      (DEPTH),
        .PERIOD_RST (32'd0)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HSEL      (HSEL),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
`ifdef PORT_SEQ_IRQ_EN
        .irq       (irq),
`endif
        .oPort     (oPort),
        .busy      (busy)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic ahb_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, a, 2'b00};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    endtask

    task automatic ahb_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_q.push_back('{name, exp});
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, a, 2'b00};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic expect_port(input string name, input logic [31:0] v, input int gap);
        port_q.push_back('{name, v, gap});
    endtask

    // Read monitor: a read address phase seen at a posedge has its data at the next negedge.
    always begin
        logic rd_phase;
        rd_exp_t e;
        @(posedge HCLK);
        rd_phase = HSEL && HREADY && (HTRANS != 2'b00) && !HWRITE && HRESETn;
        @(negedge HCLK);
        if (rd_phase) begin
            if (rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got 0x%08h, expected no read", HRDATA);
            end else begin
                e = rd_q.pop_front();
                check(e.name, HRDATA, e.val);
            end
        end
    end

    // Port monitor: every oPort change must match the next queued value and cycle gap.
    logic [31:0] last_port = '0;
    int          last_cyc = 0;
    always @(negedge HCLK) begin
        port_exp_t e;
        if (oPort !== last_port) begin
            if (port_q.size() == 0) begin
                check("port_unexpected_change", oPort, last_port);
            end else begin
                e = port_q.pop_front();
                check(e.name, oPort, e.val);
                if (e.gap >= 0) check({e.name, "_gap"}, 32'(cyc - last_cyc), 32'(e.gap));
            end
            last_port = oPort;
            last_cyc  = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        check("rst_oport", oPort, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
        ahb_read(A_STATUS, 32'h0001_0000, "rst_status");
        ahb_read(A_PERIOD, 32'h0, "rst_period");
        ahb_read(A_CTRL, 32'h0, "rst_ctrl");

        // PERIOD=2: each value held 3 cycles
        ahb_write(A_PERIOD, 32'd2);
        ahb_write(A_DATA, 32'hA);
        ahb_write(A_DATA, 32'hB);
        ahb_write(A_DATA, 32'hC);
        expect_port("seq_a", 32'hA, -1);
        expect_port("seq_b", 32'hB, 3);
        expect_port("seq_c", 32'hC, 3);
        ahb_write(A_CTRL, 32'h5);
        for (int i = 0; i < 60 && oPort !== 32'hC; i++) @(negedge HCLK);
        check("seq_c_seen", oPort, 32'hC);
        check("seq_busy_c0", {31'h0, busy}, 32'h1);
        @(negedge HCLK);
        check("seq_busy_c1", {31'h0, busy}, 32'h1);
        @(negedge HCLK);
        check("seq_busy_c2", {31'h0, busy}, 32'h1);
        @(negedge HCLK);
        check("seq_busy_drop", {31'h0, busy}, 32'h0);
        ahb_read(A_STATUS, 32'h0001_0000, "seq_status_empty");
`ifdef PORT_SEQ_IRQ_EN
        ahb_read(A_CTRL, 32'h5, "seq_ctrl_rd");
`else
        ahb_read(A_CTRL, 32'h1, "seq_ctrl_rd");
`endif
        ahb_read(A_DATA, 32'hC, "seq_data_rd");

        // PERIOD=0: back-to-back pops
        ahb_write(A_CTRL, 32'h0);
        ahb_write(A_PERIOD, 32'd0);
        ahb_write(A_DATA, 32'h11);
        ahb_write(A_DATA, 32'h22);
        ahb_write(A_DATA, 32'h33);
        ahb_write(A_DATA, 32'h44);
        expect_port("p0_w0", 32'h11, -1);
        expect_port("p0_w1", 32'h22, 1);
        expect_port("p0_w2", 32'h33, 1);
        expect_port("p0_w3", 32'h44, 1);
        ahb_write(A_CTRL, 32'h1);
        idle(10);
        ahb_read(A_STATUS, 32'h0001_0000, "p0_status");

        // Overflow with sequencing disabled
        ahb_write(A_CTRL, 32'h0);
        for (int i = 0; i <= DEPTH; i++) ahb_write(A_DATA, 32'h100 + 32'(i));
        ahb_read(A_STATUS, 32'h0006_0008, "ovf_status");
        ahb_write(A_STATUS, 32'h0004_0000);
        ahb_read(A_STATUS, 32'h0002_0008, "ovf_cleared");
        ahb_write(A_CTRL, 32'h2);
        ahb_read(A_STATUS, 32'h0001_0000, "ovf_flushed");

        // Disable mid-HOLD, then flush and re-enable
        ahb_write(A_PERIOD, 32'd20);
        ahb_write(A_DATA, 32'hA1);
        ahb_write(A_DATA, 32'hA2);
        ahb_write(A_DATA, 32'hA3);
        ahb_write(A_DATA, 32'hA4);
        expect_port("dis_a1", 32'hA1, -1);
        ahb_write(A_CTRL, 32'h1);
        idle(4);
        check("dis_busy_hold", {31'h0, busy}, 32'h1);
        ahb_write(A_CTRL, 32'h0);
        idle(2);
        check("dis_busy_idle", {31'h0, busy}, 32'h0);
        check("dis_oport_kept", oPort, 32'hA1);
        ahb_read(A_STATUS, 32'h0000_0003, "dis_level3");
        ahb_write(A_CTRL, 32'h2);
        ahb_read(A_STATUS, 32'h0001_0000, "flush_level0");
        ahb_write(A_CTRL, 32'h1);
        idle(5);
        check("reen_oport", oPort, 32'hA1);
        check("reen_busy", {31'h0, busy}, 32'h0);

        // Synchronous reset mid-HOLD with a write in its data phase
        ahb_write(A_PERIOD, 32'd50);
        ahb_write(A_DATA, 32'hB1);
        expect_port("srst_b1", 32'hB1, -1);
        idle(3);
        check("srst_busy_before", {31'h0, busy}, 32'h1);
        expect_port("srst_zero", 32'h0, -1);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, A_PERIOD, 2'b00};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h77; HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        check("srst_oport", oPort, 32'h0);
        check("srst_busy", {31'h0, busy}, 32'h0);
        ahb_read(A_PERIOD, 32'h0, "srst_period");
        ahb_read(A_STATUS, 32'h0001_0000, "srst_status");
        ahb_read(A_CTRL, 32'h0, "srst_ctrl");

        for (int i = 0; i < 20 && rd_q.size() != 0; i++) @(negedge HCLK);
        @(negedge HCLK);
        check("rd_q_drained", 32'(rd_q.size()), 32'h0);
        check("port_q_drained", 32'(port_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
